// File: rtl/user_bram_copy_engine.sv
// BRAM-to-BRAM copy engine: streams length words from a source BRAM (read latency RD_LAT)
// through a mode transform into a destination BRAM. Optional running checksum: USER_COPY_CHECKSUM_EN.
module user_bram_copy_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W:0]       length,
  input  logic [ADDR_W-1:0]     src_base,
  input  logic [ADDR_W-1:0]     dst_base,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     rd_address,
  output logic                  rd_en,
  input  logic [DATA_W-1:0]     data_in,
  output logic [ADDR_W-1:0]     write_address,
  output logic [DATA_W-1:0]     data_out,
  output logic                  wr_en,
  output logic [DATA_W/8-1:0]   wr_we,
  output logic [DATA_W-1:0]     checksum
);

  localparam int NBYTES = DATA_W / 8;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [DATA_W-1:0] DATA_ONE = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [ADDR_W:0]     r_rd_rem;
  logic [ADDR_W:0]     r_wr_rem;
  logic [ADDR_W-1:0]   r_rd_address;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_write_address;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_rd_en;
  logic                r_wr_en;
  logic                r_busy;
  logic                r_done;
  logic [RD_LAT-1:0]   r_vld_pipe;

  logic                w_accept;
  logic                w_rd_vld;

  function automatic logic [DATA_W-1:0] mode_fn(input logic [1:0] m, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      2'd1: r = ~d;
      2'd2: for (int i = 0; i < NBYTES; i++) r[8*i +: 8] = d[DATA_W-8-8*i +: 8];
      2'd3: r = d + DATA_ONE;
      default: r = d;
    endcase
    return r;
  endfunction

  assign w_accept = (r_state == IDLE) && start;
  // bit RD_LAT-1 marks the cycle in which data_in carries a requested word
  assign w_rd_vld = r_vld_pipe[RD_LAT-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mode       <= 2'd0;
      r_rd_rem     <= '0;
      r_rd_address <= '0;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_mode <= mode;
          r_busy <= 1'b1;
          if (length != '0) begin
            r_state      <= READ;
            r_rd_en      <= 1'b1;
            r_rd_address <= src_base;
            r_rd_rem     <= length - LEN_ONE;
          end else begin
            r_state <= FINISH;
            r_done  <= 1'b1;
          end
        end
        READ: if (r_rd_rem == '0) begin
          r_rd_en <= 1'b0;
          r_state <= DRAIN;
        end else begin
          r_rd_address <= r_rd_address + ADDR_ONE;
          r_rd_rem     <= r_rd_rem - LEN_ONE;
        end
        // the write on the bus when nothing remains is the final one
        DRAIN: if (r_wr_en && r_wr_rem == '0) begin
          r_state <= FINISH;
          r_done  <= 1'b1;
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= r_rd_en;
      for (int i = 1; i < RD_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_wr_rem        <= '0;
      r_write_address <= '0;
      r_data_out      <= '0;
      r_wr_en         <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_accept) begin
        r_wr_ptr <= dst_base;
        r_wr_rem <= length;
      end else if (w_rd_vld) begin
        r_wr_en         <= 1'b1;
        r_write_address <= r_wr_ptr;
        r_data_out      <= mode_fn(r_mode, data_in);
        r_wr_ptr        <= r_wr_ptr + ADDR_ONE;
        r_wr_rem        <= r_wr_rem - LEN_ONE;
      end
    end
  end

`ifdef USER_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_checksum <= '0;
    else if (w_accept) r_checksum <= '0;
    else if (r_wr_en)  r_checksum <= r_checksum + r_data_out;
  end
  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign busy          = r_busy;
  assign done          = r_done;
  assign rd_en         = r_rd_en;
  assign rd_address    = r_rd_address;
  assign wr_en         = r_wr_en;
  assign wr_we         = {NBYTES{r_wr_en}};
  assign write_address = r_write_address;
  assign data_out      = r_data_out;

endmodule

// File: tb/tb_user_bram_copy_engine.sv
// Directed bench for user_bram_copy_engine: one instance with RD_LAT=1, one with RD_LAT=3,
// each with behavioural source/destination BRAM models.
module tb_user_bram_copy_engine;

`ifdef USER_COPY_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 0, b_start = 0;
  logic [10:0] a_len = 0, b_len = 0;
  logic [9:0]  a_src = 0, a_dst = 0, b_src = 0, b_dst = 0;
  logic [1:0]  a_mode = 0, b_mode = 0;
  logic        a_busy, a_done, a_rd_en, a_wr_en, b_busy, b_done, b_rd_en, b_wr_en;
  logic [9:0]  a_ra, a_wa, b_ra, b_wa;
  logic [31:0] a_din, a_dout, a_ck, b_din, b_dout, b_ck;
  logic [3:0]  a_we, b_we;

  user_bram_copy_engine #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1)) u_a (
    .clock(clk), .reset(rst), .start(a_start), .length(a_len), .src_base(a_src),
    .dst_base(a_dst), .mode(a_mode), .busy(a_busy), .done(a_done), .rd_address(a_ra),
    .rd_en(a_rd_en), .data_in(a_din), .write_address(a_wa), .data_out(a_dout),
    .wr_en(a_wr_en), .wr_we(a_we), .checksum(a_ck));

  user_bram_copy_engine #(.DATA_W(32), .ADDR_W(10), .RD_LAT(3)) u_b (
    .clock(clk), .reset(rst), .start(b_start), .length(b_len), .src_base(b_src),
    .dst_base(b_dst), .mode(b_mode), .busy(b_busy), .done(b_done), .rd_address(b_ra),
    .rd_en(b_rd_en), .data_in(b_din), .write_address(b_wa), .data_out(b_dout),
    .wr_en(b_wr_en), .wr_we(b_we), .checksum(b_ck));

  logic [31:0] src_a [1024];
  logic [31:0] dst_a [1024];
  logic [31:0] src_b [1024];
  logic [31:0] dst_b [1024];
  logic [31:0] b_q1, b_q2;
  int a_wcnt = 0, b_wcnt = 0;

  always @(posedge clk) begin
    if (a_rd_en) a_din <= src_a[a_ra];
    b_q1 <= src_b[b_ra];
    b_q2 <= b_q1;
    b_din <= b_q2;
    if (a_wr_en) begin dst_a[a_wa] <= a_dout; a_wcnt <= a_wcnt + 1; end
    if (b_wr_en) begin dst_b[b_wa] <= b_dout; b_wcnt <= b_wcnt + 1; end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One copy: start sampled at edge E0; returns after the cycle following done.
  task automatic run(input bit b, input logic [10:0] len, input logic [9:0] src, input logic [9:0] dst,
                     input logic [1:0] md, input int exp_cyc, input int exp_wr, input string tag);
    int n, w0;
    w0 = b ? b_wcnt : a_wcnt;
    @(negedge clk);
    if (b) begin b_len = len; b_src = src; b_dst = dst; b_mode = md; b_start = 1; end
    else   begin a_len = len; a_src = src; a_dst = dst; a_mode = md; a_start = 1; end
    n = 0;
    do begin
      @(negedge clk);
      a_start = 0; b_start = 0;
      n++;
    end while (!(b ? b_done : a_done) && n < 100);
    chk({tag, "_done_cyc"}, 64'(n), 64'(exp_cyc));
    chk({tag, "_busy_fin"}, {63'd0, b ? b_busy : a_busy}, 64'd1);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {62'd0, b ? b_done : a_done, b ? b_busy : a_busy}, 64'd0);
    chk({tag, "_nwr"}, 64'((b ? b_wcnt : a_wcnt) - w0), 64'(exp_wr));
  endtask

  initial begin
    int pulses, first, w0;
    src_a[0] = 32'd1; src_a[1] = 32'd2; src_a[2] = 32'd3; src_a[3] = 32'd4;
    src_a[10'h3FE] = 32'h11223344; src_a[10'h3FF] = 32'hAABBCCDD;
    src_a[10'h010] = 32'h0F0F00FF; src_a[10'h011] = 32'h12345678;
    src_a[10'h020] = 32'hCAFEF00D;
    for (int i = 4; i < 8; i++) src_a[i] = 32'h100 + i;
    src_b[10'h040] = 32'hFFFFFFFF; src_b[10'h041] = 32'd5;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {60'd0, a_busy, a_done, a_rd_en, a_wr_en}, 64'd0);
    chk("rst_we_addr", {40'd0, a_we, a_ra, a_wa}, 64'd0);
    chk("rst_data", {a_dout, a_ck}, 64'd0);
    rst = 0;

    run(0, 11'd4, 10'h000, 10'h100, 2'd0, 7, 4, "pass4");
    chk("pass4_d0", dst_a[10'h100], 32'd1);
    chk("pass4_d1", dst_a[10'h101], 32'd2);
    chk("pass4_d2", dst_a[10'h102], 32'd3);
    chk("pass4_d3", dst_a[10'h103], 32'd4);
    chk("pass4_ck", a_ck, CK ? 32'd10 : 32'd0);
    chk("idle_we", {59'd0, a_wr_en, a_we}, 64'd0);
    chk("hold_dout", a_dout, 32'd4);

    run(0, 11'd0, 10'h000, 10'h000, 2'd0, 1, 0, "len0");
    chk("len0_ck", a_ck, 32'd0);

    run(0, 11'd3, 10'h3FE, 10'h3FF, 2'd2, 6, 3, "brev");
    chk("brev_d3ff", dst_a[10'h3FF], 32'h44332211);
    chk("brev_d000", dst_a[10'h000], 32'hDDCCBBAA);
    chk("brev_d001", dst_a[10'h001], 32'h01000000);
    chk("brev_ck", a_ck, CK ? 32'h22FFDDBB : 32'd0);

    run(0, 11'd1, 10'h010, 10'h200, 2'd1, 4, 1, "inv");
    chk("inv_d", dst_a[10'h200], 32'hF0F0FF00);

    run(1, 11'd2, 10'h040, 10'h050, 2'd3, 7, 2, "inc3");
    chk("inc3_d0", dst_b[10'h050], 32'd0);
    chk("inc3_d1", dst_b[10'h051], 32'd6);
    chk("inc3_ck", b_ck, CK ? 32'd6 : 32'd0);

    // second start mid-copy must be ignored
    w0 = a_wcnt;
    @(negedge clk);
    a_len = 11'd4; a_src = 10'h000; a_dst = 10'h180; a_mode = 2'd0; a_start = 1;
    pulses = 0; first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      a_start = (c == 2);
      if (c == 2) begin a_len = 11'd2; a_src = 10'h010; a_dst = 10'h300; a_mode = 2'd1; end
      if (a_done) begin pulses++; if (first == 0) first = c; end
    end
    chk("mid_pulses", 64'(pulses), 64'd1);
    chk("mid_cyc", 64'(first), 64'd7);
    chk("mid_nwr", 64'(a_wcnt - w0), 64'd4);
    chk("mid_d0", dst_a[10'h180], 32'd1);
    chk("mid_d3", dst_a[10'h183], 32'd4);

    // async reset during READ
    @(negedge clk);
    a_len = 11'd8; a_src = 10'h000; a_dst = 10'h1C0; a_mode = 2'd0; a_start = 1;
    @(negedge clk); a_start = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_ctl", {60'd0, a_busy, a_done, a_rd_en, a_wr_en}, 64'd0);
    chk("arst_we_addr", {40'd0, a_we, a_ra, a_wa}, 64'd0);
    chk("arst_data", {a_dout, a_ck}, 64'd0);
    @(negedge clk); rst = 0;
    run(0, 11'd1, 10'h020, 10'h220, 2'd0, 4, 1, "post_rst");
    chk("post_rst_d", dst_a[10'h220], 32'hCAFEF00D);
    chk("post_rst_ck", a_ck, CK ? 32'hCAFEF00D : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
